// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default geometry,
// the window builder state encoding and the window flat-offset helper.
package conv_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_IMAGE_SIZE  = 16;
   localparam int DEF_KERNEL_SIZE = 3;
   localparam int DEF_ADDR_SIZE   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } wb_state_t;

   // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
   function automatic int win_idx(input int r, input int c, input int k, input int dw);
      return (r * k + c) * dw;
   endfunction

endpackage

// File: rtl/window_builder_line_buffer.sv
// One image line of storage for the window builder. Single address shared by
// the write and read ports; the read returns the value held before this
// cycle's write, so a chain of these shifts a column down by one row per accept.
module line_buffer
   import conv_pkg::*;
#(
   parameter int IMAGE_SIZE = DEF_IMAGE_SIZE,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_SIZE  = DEF_ADDR_SIZE
)(
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_SIZE-1:0]  i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [IMAGE_SIZE];

   assign o_rdata = r_mem[i_addr];

   // Line storage is data only, never reset; overwritten before it is ever used.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/window_builder.sv
// Sliding-window generator: turns a row-major pixel stream into
// KERNEL_SIZE x KERNEL_SIZE windows with valid/ready on both sides.
// Optional feature macro: WINDOW_BUILDER_ERR_EN adds sticky protocol error
// flags err_no_sof and err_mid_sof (absent in the default build).
module window_builder
   import conv_pkg::*;
#(
   parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_SIZE   = DEF_ADDR_SIZE
)(
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [DATA_WIDTH-1:0]                       in_data,
   input  logic                                        in_sof,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_window,
   output logic [ADDR_SIZE-1:0]                        out_row,
   output logic [ADDR_SIZE-1:0]                        out_col,
   output logic                                        out_eof
`ifdef WINDOW_BUILDER_ERR_EN
   ,
   output logic                                        err_no_sof,
   output logic                                        err_mid_sof
`endif
);

   localparam int                   WIN_W   = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
   localparam logic [ADDR_SIZE-1:0] LP_KM1  = ADDR_SIZE'(KERNEL_SIZE - 1);
   localparam logic [ADDR_SIZE-1:0] LP_LAST = ADDR_SIZE'(IMAGE_SIZE - 1);

   wb_state_t             r_state, w_state_nx;
   logic [ADDR_SIZE-1:0]  r_row, r_col, w_row_nx, w_col_nx;
   logic [ADDR_SIZE-1:0]  w_px_row, w_px_col;
   logic                  w_accept, w_store, w_emit, w_last;

   logic                  r_out_valid, r_out_eof;
   logic [ADDR_SIZE-1:0]  r_out_row, r_out_col;
   logic [WIN_W-1:0]      r_win;

   logic [DATA_WIDTH-1:0] w_lb_wd  [KERNEL_SIZE-1];
   logic [DATA_WIDTH-1:0] w_lb_rd  [KERNEL_SIZE-1];
   logic [DATA_WIDTH-1:0] w_colvec [KERNEL_SIZE];

   // An input accept is only possible when the output slot is empty or
   // being drained this cycle, so a pending window is never overwritten.
   assign in_ready = rst && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   assign out_valid  = r_out_valid;
   assign out_window = r_win;
   assign out_row    = r_out_row;
   assign out_col    = r_out_col;
   assign out_eof    = r_out_eof;

   // Chained line buffers: line[0] takes the new pixel, line[k] takes line[k-1].
   for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_lb
      if (k == 0) begin : g_head
         assign w_lb_wd[k] = in_data;
      end else begin : g_tail
         assign w_lb_wd[k] = w_lb_rd[k-1];
      end
      line_buffer #(
         .IMAGE_SIZE (IMAGE_SIZE),
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_SIZE  (ADDR_SIZE)
      ) u_line (
         .clk     (clk),
         .i_we    (w_store),
         .i_addr  (w_px_col),
         .i_wdata (w_lb_wd[k]),
         .o_rdata (w_lb_rd[k])
      );
   end

   // Column vector, top (oldest row) to bottom (incoming pixel).
   for (genvar r = 0; r < KERNEL_SIZE - 1; r++) begin : g_col
      assign w_colvec[r] = w_lb_rd[KERNEL_SIZE-2-r];
   end
   assign w_colvec[KERNEL_SIZE-1] = in_data;

   // State, row and column registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_row   <= w_row_nx;
         r_col   <= w_col_nx;
      end
   end

   // Next state, coordinate advance, and store/emit decisions for this accept.
   always_comb begin
      w_state_nx = r_state;
      w_row_nx   = r_row;
      w_col_nx   = r_col;
      w_px_row   = r_row;
      w_px_col   = r_col;
      w_store    = 1'b0;
      w_emit     = 1'b0;
      w_last     = 1'b0;
      if (w_accept) begin
         if (in_sof) begin
            // Start-of-frame always restarts at (0,0), whatever the state.
            w_store    = 1'b1;
            w_px_row   = '0;
            w_px_col   = '0;
            w_row_nx   = '0;
            w_col_nx   = ADDR_SIZE'(1);
            w_state_nx = FILL;
         end else if (r_state != IDLE) begin
            w_store = 1'b1;
            w_emit  = (r_row >= LP_KM1) && (r_col >= LP_KM1);
            w_last  = (r_row == LP_LAST) && (r_col == LP_LAST);
            if (w_last) begin
               w_row_nx   = '0;
               w_col_nx   = '0;
               w_state_nx = IDLE;
            end else begin
               if (r_col == LP_LAST) begin
                  w_col_nx = '0;
                  w_row_nx = r_row + ADDR_SIZE'(1);
               end else begin
                  w_col_nx = r_col + ADDR_SIZE'(1);
               end
               if ((r_row == LP_KM1) && (r_col == '0)) begin
                  w_state_nx = RUN;
               end
            end
         end
      end
   end

   // Window shift register: older columns move left, the new column enters at c=K-1.
   always_ff @(posedge clk) begin
      if (w_store) begin
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
               if (c == KERNEL_SIZE - 1) begin
                  r_win[win_idx(r, c, KERNEL_SIZE, DATA_WIDTH) +: DATA_WIDTH] <= w_colvec[r];
               end else begin
                  r_win[win_idx(r, c, KERNEL_SIZE, DATA_WIDTH) +: DATA_WIDTH] <=
                     r_win[win_idx(r, c + 1, KERNEL_SIZE, DATA_WIDTH) +: DATA_WIDTH];
               end
            end
         end
      end
   end

   // Output slot: load on an emitting accept, clear once drained, hold under backpressure.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_eof   <= 1'b0;
         r_out_row   <= '0;
         r_out_col   <= '0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_eof   <= w_last;
         r_out_row   <= w_px_row - LP_KM1;
         r_out_col   <= w_px_col - LP_KM1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
         r_out_eof   <= 1'b0;
      end
   end

`ifdef WINDOW_BUILDER_ERR_EN
   logic r_err_no_sof, r_err_mid_sof;

   // Sticky protocol flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_err_no_sof  <= 1'b0;
         r_err_mid_sof <= 1'b0;
      end else begin
         if (w_accept && !in_sof && (r_state == IDLE)) begin
            r_err_no_sof <= 1'b1;
         end
         if (w_accept && in_sof && (r_state != IDLE)) begin
            r_err_mid_sof <= 1'b1;
         end
      end
   end

   assign err_no_sof  = r_err_no_sof;
   assign err_mid_sof = r_err_mid_sof;
`endif

endmodule

// File: tb/tb_window_builder.sv
// Directed bench for window_builder at default geometry (16x16 image, 3x3 kernel).
// Optional feature macro: WINDOW_BUILDER_ERR_EN enables error-flag checks.
module tb_window_builder;

   localparam int IS   = 16;
   localparam int K    = 3;
   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int WW   = K * K * DW;
   localparam int NW1  = IS - K + 1;
   localparam int NWIN = NW1 * NW1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_sof;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready, out_eof;
   logic [WW-1:0] out_window;
   logic [AW-1:0] out_row, out_col;
`ifdef WINDOW_BUILDER_ERR_EN
   logic          err_no_sof, err_mid_sof;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [WW-1:0] q_win [$];
   logic [AW-1:0] q_row [$];
   logic [AW-1:0] q_col [$];
   logic          q_eof [$];

   always #5 clk = ~clk;

   window_builder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_window (out_window),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_eof    (out_eof)
`ifdef WINDOW_BUILDER_ERR_EN
      ,
      .err_no_sof (err_no_sof),
      .err_mid_sof(err_mid_sof)
`endif
   );

   // Record every window transferred at the coming rising edge.
   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         q_win.push_back(out_window);
         q_row.push_back(out_row);
         q_col.push_back(out_col);
         q_eof.push_back(out_eof);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [WW-1:0] exp_win(input int base, input int wr, input int wc);
      logic [WW-1:0] w;
      w = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            w[(r*K+c)*DW +: DW] = DW'(base + (wr + r) * IS + wc + c);
      return w;
   endfunction

   // Number of recorded windows q[start..start+n-1] that differ from frame windows 0..n-1.
   function automatic int frame_errs(input int base, input int start, input int n);
      int e;
      e = 0;
      for (int j = 0; j < n; j++) begin
         if (start + j >= q_win.size()) begin
            e++;
         end else if (q_win[start+j] !== exp_win(base, j / NW1, j % NW1) ||
                      q_row[start+j] !== AW'(j / NW1) ||
                      q_col[start+j] !== AW'(j % NW1) ||
                      q_eof[start+j] !== (j == NWIN - 1)) begin
            e++;
         end
      end
      return e;
   endfunction

   task automatic push_px(input logic [DW-1:0] d, input logic sof);
      int   guard;
      logic acc;
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      guard    = 0;
      acc      = 1'b0;
      while (!acc && guard < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) begin
         n_checks++;
         $display("FAIL push_timeout: in_ready=0 for %0d cycles, required 1", guard);
      end
      in_sof = 1'b0;
   endtask

   task automatic send_frame(input int base, input int n, input logic sof);
      for (int i = 0; i < n; i++) push_px(DW'(base + i), sof && (i == 0));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, want 0", out_valid); else n_pass++;
      n_checks++; if (out_eof !== 1'b0) $display("FAIL rst_out_eof: got %b, want 0", out_eof); else n_pass++;
      n_checks++; if (out_row !== 4'd0) $display("FAIL rst_out_row: got %0d, want 0", out_row); else n_pass++;
      n_checks++; if (out_col !== 4'd0) $display("FAIL rst_out_col: got %0d, want 0", out_col); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low: got %b, want 0", in_ready); else n_pass++;
`ifdef WINDOW_BUILDER_ERR_EN
      n_checks++; if (err_no_sof !== 1'b0) $display("FAIL rst_err_no_sof: got %b, want 0", err_no_sof); else n_pass++;
      n_checks++; if (err_mid_sof !== 1'b0) $display("FAIL rst_err_mid_sof: got %b, want 0", err_mid_sof); else n_pass++;
`endif
      rst = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_high: got %b, want 1", in_ready); else n_pass++;
   endtask

   task automatic test_ramp;
      int            first_at, ne;
      logic [WW-1:0] first_win, last_exp;
      logic [AW-1:0] fr, fc;
      int            lw [9] = '{221, 222, 223, 237, 238, 239, 253, 254, 255};
      q_win.delete(); q_row.delete(); q_col.delete(); q_eof.delete();
      first_at = -1; first_win = '0; fr = '1; fc = '1;
      for (int i = 0; i < IS * IS; i++) begin
         push_px(DW'(i), i == 0);
         if (first_at < 0 && out_valid === 1'b1) begin
            first_at = i + 1; first_win = out_window; fr = out_row; fc = out_col;
         end
      end
      idle(3);
      for (int j = 0; j < 9; j++) last_exp[j*DW +: DW] = DW'(lw[j]);
      n_checks++; if (first_at != 35) $display("FAIL ramp_first_latency: valid after accept %0d, want 35", first_at); else n_pass++;
      n_checks++; if (first_win !== exp_win(0, 0, 0)) $display("FAIL ramp_first_window: got %h, want %h", first_win, exp_win(0, 0, 0)); else n_pass++;
      n_checks++; if (fr !== 4'd0 || fc !== 4'd0) $display("FAIL ramp_first_coord: got %0d/%0d, want 0/0", fr, fc); else n_pass++;
      n_checks++; if (q_win.size() != NWIN) $display("FAIL ramp_count: got %0d, want %0d", q_win.size(), NWIN); else n_pass++;
      ne = frame_errs(0, 0, NWIN);
      n_checks++; if (ne != 0) $display("FAIL ramp_windows: %0d bad windows, want 0", ne); else n_pass++;
      n_checks++; if (q_win[q_win.size()-1] !== last_exp) $display("FAIL ramp_last_window: got %h, want %h", q_win[q_win.size()-1], last_exp); else n_pass++;
      n_checks++; if (q_row[q_row.size()-1] !== 4'd13 || q_col[q_col.size()-1] !== 4'd13)
         $display("FAIL ramp_last_coord: got %0d/%0d, want 13/13", q_row[q_row.size()-1], q_col[q_col.size()-1]); else n_pass++;
      ne = 0;
      foreach (q_eof[j]) if (q_eof[j] === 1'b1) ne++;
      n_checks++; if (ne != 1 || q_eof[q_eof.size()-1] !== 1'b1) $display("FAIL ramp_eof: %0d eof windows, want exactly 1 on last", ne); else n_pass++;
   endtask

   task automatic test_backpressure;
      int            g, bad, ne, idx;
      logic [WW-1:0] hold_win;
      logic [AW-1:0] hold_row, hold_col;
      q_win.delete(); q_row.delete(); q_col.delete(); q_eof.delete();
      g = 0; bad = 0; idx = 0; hold_win = '0; hold_row = '0; hold_col = '0;
      fork
         send_frame(100, IS * IS, 1'b1);
         begin
            while (!(out_valid === 1'b1 && q_win.size() >= 20) && g < 2000) begin
               @(posedge clk);
               #2;
               g++;
            end
            out_ready = 1'b0;
            idx = q_win.size();
            hold_win = out_window; hold_row = out_row; hold_col = out_col;
            repeat (5) begin
               @(negedge clk);
               if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_window !== hold_win ||
                   out_row !== hold_row || out_col !== hold_col) bad++;
            end
            @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
      join
      idle(3);
      n_checks++; if (g >= 2000) $display("FAIL bp_reach_stall: waited %0d cycles, want < 2000", g); else n_pass++;
      n_checks++; if (bad != 0) $display("FAIL bp_stable: %0d unstable stall cycles, want 0", bad); else n_pass++;
      n_checks++; if (hold_win !== exp_win(100, idx / NW1, idx % NW1))
         $display("FAIL bp_held_window: got %h, want %h", hold_win, exp_win(100, idx / NW1, idx % NW1)); else n_pass++;
      n_checks++; if (q_win.size() != NWIN) $display("FAIL bp_count: got %0d, want %0d", q_win.size(), NWIN); else n_pass++;
      ne = frame_errs(100, 0, NWIN);
      n_checks++; if (ne != 0) $display("FAIL bp_windows: %0d bad windows, want 0", ne); else n_pass++;
   endtask

   task automatic test_no_sof;
      int ne;
      q_win.delete(); q_row.delete(); q_col.delete(); q_eof.delete();
`ifdef WINDOW_BUILDER_ERR_EN
      n_checks++; if (err_no_sof !== 1'b0) $display("FAIL nosof_err_before: got %b, want 0", err_no_sof); else n_pass++;
`endif
      for (int i = 0; i < 10; i++) push_px(DW'(500 + i), 1'b0);
      idle(2);
      n_checks++; if (q_win.size() != 0) $display("FAIL nosof_dropped: got %0d windows, want 0", q_win.size()); else n_pass++;
      send_frame(1000, IS * IS, 1'b1);
      idle(3);
      n_checks++; if (q_win.size() != NWIN) $display("FAIL nosof_count: got %0d, want %0d", q_win.size(), NWIN); else n_pass++;
      ne = frame_errs(1000, 0, NWIN);
      n_checks++; if (ne != 0) $display("FAIL nosof_windows: %0d bad windows, want 0", ne); else n_pass++;
`ifdef WINDOW_BUILDER_ERR_EN
      n_checks++; if (err_no_sof !== 1'b1) $display("FAIL nosof_err: got %b, want 1", err_no_sof); else n_pass++;
      n_checks++; if (err_mid_sof !== 1'b0) $display("FAIL nosof_err_mid: got %b, want 0", err_mid_sof); else n_pass++;
`endif
   endtask

   task automatic test_mid_sof;
      int ne;
      q_win.delete(); q_row.delete(); q_col.delete(); q_eof.delete();
      send_frame(2000, 100, 1'b1);
      send_frame(3000, IS * IS, 1'b1);
      idle(3);
      n_checks++; if (q_win.size() != 58 + NWIN) $display("FAIL midsof_count: got %0d, want %0d", q_win.size(), 58 + NWIN); else n_pass++;
      ne = frame_errs(2000, 0, 58);
      n_checks++; if (ne != 0) $display("FAIL midsof_partial: %0d bad windows, want 0", ne); else n_pass++;
      ne = frame_errs(3000, 58, NWIN);
      n_checks++; if (ne != 0) $display("FAIL midsof_fresh: %0d bad windows, want 0", ne); else n_pass++;
      n_checks++; if (q_row[58] !== 4'd0 || q_col[58] !== 4'd0)
         $display("FAIL midsof_first_coord: got %0d/%0d, want 0/0", q_row[58], q_col[58]); else n_pass++;
`ifdef WINDOW_BUILDER_ERR_EN
      n_checks++; if (err_mid_sof !== 1'b1) $display("FAIL midsof_err: got %b, want 1", err_mid_sof); else n_pass++;
`endif
   endtask

   task automatic test_rst_mid;
      int ne;
      send_frame(4000, 51, 1'b1);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_pending: got %b, want 1", out_valid); else n_pass++;
      rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready: got %b, want 0", in_ready); else n_pass++;
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b, want 0", out_valid); else n_pass++;
      rst = 1'b1; out_ready = 1'b1;
      q_win.delete(); q_row.delete(); q_col.delete(); q_eof.delete();
      for (int i = 0; i < 20; i++) push_px(DW'(4500 + i), 1'b0);
      idle(2);
      n_checks++; if (q_win.size() != 0) $display("FAIL rstmid_idle: got %0d windows, want 0", q_win.size()); else n_pass++;
      send_frame(5000, IS * IS, 1'b1);
      idle(3);
      n_checks++; if (q_win.size() != NWIN) $display("FAIL rstmid_count: got %0d, want %0d", q_win.size(), NWIN); else n_pass++;
      ne = frame_errs(5000, 0, NWIN);
      n_checks++; if (ne != 0) $display("FAIL rstmid_windows: %0d bad windows, want 0", ne); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_backpressure();
      test_no_sof();
      test_mid_sof();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
